upsp_wrt_arbiter: RTL

- Shares the single output AXI-stream path between N_PARALLEL upsampling units that write result pixels.
- Round-robin arbitration over the per-unit write requests; one winner per beat is forwarded through a one-stage output register.
- Counts columns and rows of the destination frame, generating tlast per row, tuser on the first beat of the frame, and a done pulse at frame end.
- Sits between the upsampling array and the output FIFO / master stream, started by the UPSTART pulse from the config register file.

---
 rtl/upsp_wrt_arbiter_if.sv | 25 ++
 rtl/upsp_wrt_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/upsp_wrt_arbiter_if.sv
// Stream bundle between the upsampling units, the write arbiter and the output stream.
// Modport master is the arbiter's view; slave is the surrounding units/sink view.
interface upsp_wrt_arbiter_if #(
    parameter int unsigned N_PARALLEL         = 4,
    parameter int unsigned UPSP_WRTDATA_WIDTH = 32
);
    logic [N_PARALLEL-1:0]                    upsp_wvalid;
    logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0] upsp_wdata;
    logic [N_PARALLEL-1:0]                    upsp_wready;
    logic                                     m_axis_tvalid;
    logic [UPSP_WRTDATA_WIDTH-1:0]            m_axis_tdata;
    logic                                     m_axis_tlast;
    logic                                     m_axis_tuser;
    logic                                     m_axis_tready;

    modport master (
        input  upsp_wvalid, upsp_wdata, m_axis_tready,
        output upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output upsp_wvalid, upsp_wdata, m_axis_tready,
        input  upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/upsp_wrt_arbiter.sv
// Round-robin write arbiter merging N_PARALLEL upsampling units into one AXI stream frame.
// Optional UPSP_ARB_BURST_EN: a winner keeps its grant for up to BURST_LEN beats.
module upsp_wrt_arbiter #(
    parameter int unsigned N_PARALLEL         = 4,
    parameter int unsigned UPSP_WRTDATA_WIDTH = 32,
    parameter int unsigned DST_IMG_WIDTH      = 3840,
    parameter int unsigned DST_IMG_HEIGHT     = 2160,
    parameter int unsigned CNT_WIDTH          = 16,
    parameter int unsigned BURST_LEN          = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    upsp_wrt_arbiter_if.master   bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int unsigned IDX_W = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
    localparam int unsigned DW    = UPSP_WRTDATA_WIDTH;

    if (N_PARALLEL < 2 || BURST_LEN < 1 ||
        DST_IMG_WIDTH > (64'd1 << CNT_WIDTH) || DST_IMG_HEIGHT > (64'd1 << CNT_WIDTH)) begin : g_param_check
        $error("upsp_wrt_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       scan_idx;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       ptr_inc;
    logic [IDX_W-1:0]       ptr_nxt;
    logic [N_PARALLEL-1:0]  gnt_vec;
    logic                   gnt_any;
    logic                   load;
    logic                   accept;
    logic                   col_end;
    logic                   frame_end;
    logic [CNT_WIDTH-1:0]   col;
    logic [CNT_WIDTH-1:0]   row;
    logic                   first_beat;
    logic [DW-1:0]          gnt_data;

    assign load      = (state == RUN) && (!bus.m_axis_tvalid || bus.m_axis_tready);
    assign accept    = load && gnt_any;
    assign col_end   = (col == CNT_WIDTH'(DST_IMG_WIDTH - 1));
    assign frame_end = col_end && (row == CNT_WIDTH'(DST_IMG_HEIGHT - 1));
    assign ptr_inc   = (gnt_idx == IDX_W'(N_PARALLEL - 1)) ? '0 : gnt_idx + 1'b1;
    assign gnt_data  = bus.upsp_wdata[gnt_idx*DW +: DW];

    // Search for the first requester starting at the round-robin pointer, with wrap-around.
    always_comb begin
        gnt_vec  = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_PARALLEL; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr) + k) % N_PARALLEL);
            if (!gnt_any && bus.upsp_wvalid[scan_idx]) begin
                gnt_any           = 1'b1;
                gnt_idx           = scan_idx;
                gnt_vec[scan_idx] = 1'b1;
            end
        end
    end

    assign bus.upsp_wready = load ? gnt_vec : '0;

`ifdef UPSP_ARB_BURST_EN
    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic          burst_end;

    // A grant away from the pointer means the previous winner dropped out: new burst.
    always_comb begin
        burst_nxt = (gnt_idx == rr_ptr) ? burst_cnt + 1'b1 : BW'(1);
        burst_end = (burst_nxt >= BW'(BURST_LEN)) || col_end;
        ptr_nxt   = burst_end ? ptr_inc : gnt_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (state == IDLE && start) begin
            burst_cnt <= '0;
        end else if (accept) begin
            burst_cnt <= burst_end ? '0 : burst_nxt;
        end
    end
`else
    assign ptr_nxt = ptr_inc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            col               <= '0;
            row               <= '0;
            first_beat        <= 1'b0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            bus.m_axis_tvalid <= 1'b0;
            bus.m_axis_tdata  <= '0;
            bus.m_axis_tlast  <= 1'b0;
            bus.m_axis_tuser  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                bus.m_axis_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        rr_ptr     <= '0;
                        col        <= '0;
                        row        <= '0;
                        first_beat <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        bus.m_axis_tvalid <= 1'b1;
                        bus.m_axis_tdata  <= gnt_data;
                        bus.m_axis_tlast  <= col_end;
                        bus.m_axis_tuser  <= first_beat;
                        first_beat        <= 1'b0;
                        rr_ptr            <= ptr_nxt;
                        if (col_end) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (frame_end) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
